// File: rtl/logic_exec_stage_pkg.sv
// Shared definitions for the logic execution stage.
// Holds the 2-bit operation encodings and the result buffer depth.
package logic_exec_stage_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise operation unit.
// Optionally inverts the operands according to BubblesMask, then applies Op.
// Ports:
//   A, B   : operands (NrOfBits)
//   Op     : operation select (AND, OR, XOR, NOR)
//   Result : operation result (NrOfBits)
//   Zero   : high when Result is all zeros
module logic_op_unit
    import logic_exec_stage_pkg::*;
#(
    parameter int unsigned NrOfBits    = 32,
    parameter int unsigned BubblesMask = 0
) (
    input  logic [NrOfBits-1:0] A,
    input  logic [NrOfBits-1:0] B,
    input  logic [1:0]          Op,
    output logic [NrOfBits-1:0] Result,
    output logic                Zero
);

    localparam bit InvA = (BubblesMask & 32'd1) != 0;
    localparam bit InvB = (BubblesMask & 32'd2) != 0;

    logic [NrOfBits-1:0] a_m;
    logic [NrOfBits-1:0] b_m;

    always_comb begin
        a_m = InvA ? ~A : A;
        b_m = InvB ? ~B : B;
        case (Op)
            OP_AND:  Result = a_m & b_m;
            OP_OR:   Result = a_m | b_m;
            OP_XOR:  Result = a_m ^ b_m;
            OP_NOR:  Result = ~(a_m | b_m);
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end

endmodule

// File: rtl/logic_exec_stage.sv
// Logic execution stage with a 2-entry in-order result buffer.
// Accepted requests are computed by logic_op_unit and stored with their zero
// flag; results appear one cycle after acceptance and drain in order.
// Optional feature: define LOGIC_EXEC_STAGE_PARITY_EN to add Out_Parity, the
// XOR reduction of the head result, stored per entry.
// Ports:
//   Clock, Reset         : clock, synchronous active-high reset
//   In_Valid / In_Ready  : request handshake (In_Ready is registered)
//   In_Op, In_A, In_B    : operation select and operands
//   Out_Valid / Out_Ready: result handshake
//   Out_Result, Out_Zero : head result and its zero flag (0 when empty)
//   Out_Parity           : head result parity (only with the macro defined)
module logic_exec_stage
    import logic_exec_stage_pkg::*;
#(
    parameter int unsigned NrOfBits    = 32,
    parameter int unsigned BubblesMask = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [1:0]          In_Op,
    input  logic [NrOfBits-1:0] In_A,
    input  logic [NrOfBits-1:0] In_B,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic [NrOfBits-1:0] Out_Result,
    output logic                Out_Zero
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
    ,
    output logic                Out_Parity
`endif
);

    localparam logic [1:0] DepthCnt = 2'(BUF_DEPTH);

    logic [NrOfBits-1:0] res_q [BUF_DEPTH];
    logic                zero_q [BUF_DEPTH];
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
    logic                par_q [BUF_DEPTH];
`endif
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic                in_ready_q;

    logic [NrOfBits-1:0] op_result;
    logic                op_zero;
    logic                push;
    logic                pop;

    logic_op_unit #(
        .NrOfBits    (NrOfBits),
        .BubblesMask (BubblesMask)
    ) u_op_unit (
        .A      (In_A),
        .B      (In_B),
        .Op     (In_Op),
        .Result (op_result),
        .Zero   (op_zero)
    );

    assign push = In_Valid && in_ready_q;
    assign pop  = Out_Valid && Out_Ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                res_q[i]  <= '0;
                zero_q[i] <= 1'b0;
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
                par_q[i]  <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                res_q[wr_ptr_q]  <= op_result;
                zero_q[wr_ptr_q] <= op_zero;
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
                par_q[wr_ptr_q]  <= ^op_result;
`endif
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            // Registered from the next count, so a slot freed by a pop is
            // only offered on the following cycle.
            in_ready_q <= (count_d < DepthCnt);
        end
    end

    always_comb begin
        In_Ready   = in_ready_q;
        Out_Valid  = (count_q != 2'd0);
        Out_Result = Out_Valid ? res_q[rd_ptr_q] : '0;
        Out_Zero   = Out_Valid ? zero_q[rd_ptr_q] : 1'b0;
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
        Out_Parity = Out_Valid ? par_q[rd_ptr_q] : 1'b0;
`endif
    end

endmodule

// File: tb/tb_logic_exec_stage.sv
module tb_logic_exec_stage;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       par;
    } exp_t;

    logic       Clock;
    logic       Reset;
    logic       In_Valid;
    logic       In_Ready;
    logic [1:0] In_Op;
    logic [7:0] In_A;
    logic [7:0] In_B;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [7:0] Out_Result;
    logic       Out_Zero;
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
    logic       Out_Parity;
    logic       m1_parity;
    logic       m3_parity;
`endif
    logic       m1_in_ready, m1_valid, m1_zero;
    logic       m3_in_ready, m3_valid, m3_zero;
    logic [7:0] m1_result, m3_result;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic_exec_stage #(.NrOfBits(8), .BubblesMask(0)) u_dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Op      (In_Op),
        .In_A       (In_A),
        .In_B       (In_B),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Result (Out_Result),
        .Out_Zero   (Out_Zero)
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
        ,
        .Out_Parity (Out_Parity)
`endif
    );

    logic_exec_stage #(.NrOfBits(8), .BubblesMask(1)) u_dut_m1 (
        .Clock      (Clock),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Ready   (m1_in_ready),
        .In_Op      (In_Op),
        .In_A       (In_A),
        .In_B       (In_B),
        .Out_Valid  (m1_valid),
        .Out_Ready  (Out_Ready),
        .Out_Result (m1_result),
        .Out_Zero   (m1_zero)
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
        ,
        .Out_Parity (m1_parity)
`endif
    );

    logic_exec_stage #(.NrOfBits(8), .BubblesMask(3)) u_dut_m3 (
        .Clock      (Clock),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Ready   (m3_in_ready),
        .In_Op      (In_Op),
        .In_A       (In_A),
        .In_B       (In_B),
        .Out_Valid  (m3_valid),
        .Out_Ready  (Out_Ready),
        .Out_Result (m3_result),
        .Out_Zero   (m3_zero)
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
        ,
        .Out_Parity (m3_parity)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: operand inversion, then the selected bitwise op.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input int mask);
        logic [7:0] am;
        logic [7:0] bm;
        am = mask[0] ? ~a : a;
        bm = mask[1] ? ~b : b;
        case (op)
            2'b00:   return am & bm;
            2'b01:   return am | bm;
            2'b10:   return am ^ bm;
            default: return ~(am | bm);
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives a request from posedge+1 until accepted; returns at posedge+1.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        bit   acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        In_Op    = op;
        In_A     = a;
        In_B     = b;
        In_Valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge Clock);
            if (In_Ready) begin
                acc = 1'b1;
            end else begin
                @(posedge Clock);
                #1;
                n++;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=stalled required=accepted at %0t", $time);
        end else begin
            e.res  = model(op, a, b, 0);
            e.zero = (e.res == 8'h00);
            e.par  = ^e.res;
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        Out_Ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            @(posedge Clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
        end
        Out_Ready = 1'b0;
    endtask

    // Scoreboard monitor: a transfer at the coming edge is seen at the negedge.
    always @(negedge Clock) begin
        if (!Reset && Out_Valid && Out_Ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=0x%h required=none at %0t",
                         Out_Result, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", Out_Result, e.res);
                check("sb_zero", {7'd0, Out_Zero}, {7'd0, e.zero});
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
                check("sb_parity", {7'd0, Out_Parity}, {7'd0, e.par});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset     = 1'b1;
        In_Valid  = 1'b0;
        In_Op     = 2'b00;
        In_A      = 8'h00;
        In_B      = 8'h00;
        Out_Ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Reset state
        @(negedge Clock);
        check("rst_valid", {7'd0, Out_Valid}, 8'd0);
        check("rst_result", Out_Result, 8'h00);
        check("rst_zero", {7'd0, Out_Zero}, 8'd0);
        check("rst_in_ready", {7'd0, In_Ready}, 8'd1);
        @(posedge Clock);
        #1;

        // NOR 0F/F0 -> 00, zero flag, visible the cycle after accept
        Out_Ready = 1'b1;
        issue(2'b11, 8'h0F, 8'hF0);
        @(negedge Clock);
        check("lat_valid", {7'd0, Out_Valid}, 8'd1);
        check("lat_zero", {7'd0, Out_Zero}, 8'd1);
        @(posedge Clock);
        #1;
        drain();

        // Back-pressure: two fill the buffer, third blocked until a pop
        Out_Ready = 1'b0;
        issue(2'b00, 8'hFF, 8'h3C);
        issue(2'b01, 8'h01, 8'h02);
        In_Op = 2'b10; In_A = 8'hAA; In_B = 8'hAA; In_Valid = 1'b1;
        @(negedge Clock);
        check("full_in_ready", {7'd0, In_Ready}, 8'd0);
        check("full_hold_head", Out_Result, 8'h3C);
        @(posedge Clock);
        #1;
        check("full_hold_head2", Out_Result, 8'h3C);
        Out_Ready = 1'b1;
        @(negedge Clock);
        check("full_pop_no_ready", {7'd0, In_Ready}, 8'd0);
        @(posedge Clock);
        #1;
        @(negedge Clock);
        check("freed_slot_offered", {7'd0, In_Ready}, 8'd1);
        if (In_Ready) begin
            exp_t e;
            e.res = 8'h00; e.zero = 1'b1; e.par = 1'b0;
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
        drain();

        // Simultaneous push and pop with one entry buffered
        issue(2'b00, 8'h12, 8'hFF);
        Out_Ready = 1'b1;
        issue(2'b01, 8'h80, 8'h01);
        Out_Ready = 1'b0;
        @(negedge Clock);
        check("pp_valid", {7'd0, Out_Valid}, 8'd1);
        check("pp_in_ready", {7'd0, In_Ready}, 8'd1);
        check("pp_head", Out_Result, 8'h81);
        check("pp_zero", {7'd0, Out_Zero}, 8'd0);
        @(posedge Clock);
        #1;
        drain();

        // Operand inversion variants
        Out_Ready = 1'b1;
        issue(2'b00, 8'hF0, 8'hFF);
        @(negedge Clock);
        check("mask1_and", m1_result, 8'h0F);
        check("mask1_zero", {7'd0, m1_zero}, 8'd0);
        @(posedge Clock);
        #1;
        issue(2'b11, 8'h00, 8'h00);
        @(negedge Clock);
        check("mask3_nor", m3_result, 8'h00);
        check("mask3_zero", {7'd0, m3_zero}, 8'd1);
        @(posedge Clock);
        #1;
        drain();

        // Parity vector (and a plain XOR result without the macro)
        Out_Ready = 1'b1;
        issue(2'b10, 8'h07, 8'h00);
        @(negedge Clock);
        check("xor_result", Out_Result, 8'h07);
`ifdef LOGIC_EXEC_STAGE_PARITY_EN
        check("parity", {7'd0, Out_Parity}, 8'd1);
`endif
        @(posedge Clock);
        #1;
        drain();

        // Reset with a full buffer and a request presented in the same cycle
        issue(2'b01, 8'h55, 8'h0A);
        issue(2'b10, 8'h0F, 8'h01);
        Reset    = 1'b1;
        In_Valid = 1'b1;
        In_Op    = 2'b01;
        In_A     = 8'h11;
        In_B     = 8'h22;
        @(posedge Clock);
        #1;
        Reset    = 1'b0;
        In_Valid = 1'b0;
        sb.delete();
        @(negedge Clock);
        check("flush_valid", {7'd0, Out_Valid}, 8'd0);
        check("flush_result", Out_Result, 8'h00);
        check("flush_in_ready", {7'd0, In_Ready}, 8'd1);
        Out_Ready = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
        check("flush_no_stale", {7'd0, Out_Valid}, 8'd0);
        Out_Ready = 1'b0;

        // Stage still works after the flush
        Out_Ready = 1'b1;
        issue(2'b10, 8'h3C, 8'h0F);
        drain();
        repeat (2) @(posedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_exec_stage.md
LOGIC_EXEC_STAGE -- requirements
Module: logic_exec_stage

Interface
REQ-001 The module SHALL have parameter NrOfBits, default 32, giving the operand/result width (legal 1..64).
REQ-002 The module SHALL have parameter BubblesMask, default 0; bit0 inverts operand A and bit1 inverts operand B before the operation.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 In_Valid  input  1  the upstream request is valid.
REQ-006 In_Ready  output  1  the stage can accept a request this cycle.
REQ-007 In_Op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 In_A  input  NrOfBits  operand A.
REQ-009 In_B  input  NrOfBits  operand B.
REQ-010 Out_Valid  output  1  the head result is valid.
REQ-011 Out_Ready  input  1  the downstream consumer accepts the head result.
REQ-012 Out_Result  output  NrOfBits  the head result.
REQ-013 Out_Zero  output  1  set when the head result is all zeros.

Function
REQ-014 A request SHALL be accepted only in a cycle where In_Valid and In_Ready are both 1; a head result SHALL be consumed only in a cycle where Out_Valid and Out_Ready are both 1.
REQ-015 On acceptance, the stage SHALL compute the result from A' and B' (the operands after BubblesMask inversion) using In_Op, and SHALL write it with its zero flag into a 2-entry in-order result buffer.
REQ-016 Latency SHALL be 1 cycle: a result accepted at edge N is presented with Out_Valid=1 after edge N.
REQ-017 The buffer occupancy count SHALL take values 0..2; In_Ready SHALL equal (count<2), registered, with no combinational path from Out_Ready.
REQ-018 Out_Valid SHALL equal (count!=0); Out_Result and Out_Zero SHALL reflect the head entry and SHALL be driven to 0 when count==0.
REQ-019 A simultaneous accept and consume SHALL leave the count unchanged, advance the head, and append the new entry behind it. With count==1 the new entry SHALL become the head on the next cycle.
REQ-020 The read and write pointers SHALL be 1 bit each and SHALL wrap from 1 to 0.
REQ-021 When count==2, In_Ready SHALL be 0 even if Out_Ready=1 in the same cycle; the freed slot SHALL be offered on the following cycle.
REQ-022 Out_Result and Out_Zero SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-023 Inputs SHALL be ignored when In_Valid=0, and In_Op/In_A/In_B SHALL be ignored when In_Ready=0.

Reset
REQ-024 While Reset=1 at an edge, the stage SHALL set count and both pointers to 0, clear all buffer entries, and drive Out_Valid=0, Out_Result=0, Out_Zero=0 and In_Ready=1 after that edge.
REQ-025 A reset asserted mid-operation SHALL discard buffered results and any request presented in the same cycle.

Configuration
REQ-026 When LOGIC_EXEC_STAGE_PARITY_EN is defined, the module SHALL add an output Out_Parity (1 bit) holding the even parity (XOR reduction) of the head result, stored per entry and 0 when the buffer is empty or in reset.
REQ-027 When LOGIC_EXEC_STAGE_PARITY_EN is undefined, the port and its storage SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 A shared package SHALL hold the 2-bit op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the buffer depth constant (2).
REQ-029 The combinational operation SHALL be one sub-module, logic_op_unit (A, B, Op, BubblesMask → Result, Zero); the buffer and handshake logic SHALL live in the top level.

Verification (NrOfBits=8, BubblesMask=0 unless noted)
REQ-030 NOR, A=0x0F, B=0xF0, Out_Ready=1 → next cycle Out_Valid=1, Out_Result=0x00, Out_Zero=1.
REQ-031 Out_Ready=0, three back-to-back requests (AND 0xFF/0x3C, OR 0x01/0x02, XOR 0xAA/0xAA) → the first two are accepted and In_Ready=0 on the third. Then raising Out_Ready → the results are 0x3C, 0x03, 0x00 in order, and the third request is accepted one cycle after the first pop.
REQ-032 count==1 with a simultaneous push (OR 0x80/0x01) and pop → the count stays 1, and the next head is 0x81 with Out_Zero=0.
REQ-033 BubblesMask=1, AND, A=0xF0, B=0xFF → Out_Result=0x0F. BubblesMask=3, NOR, A=0x00, B=0x00 → Out_Result=0x00.
REQ-034 Buffer full and Reset pulsed for 1 cycle → next cycle Out_Valid=0, Out_Result=0x00, In_Ready=1, and no stale results appear afterwards.
REQ-035 With LOGIC_EXEC_STAGE_PARITY_EN defined, XOR, A=0x07, B=0x00 → Out_Parity=1. Without the macro, the same run SHALL give identical results and the port SHALL not exist.
